led_pattern_controller: RTL and testbench

LED_PATTERN_CONTROLLER -- requirements
Module: led_pattern_controller

---
 rtl/led_pattern_controller.sv | 113 +++++++++++
 tb/tb_led_pattern_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_controller.sv
// led_pattern_controller: debounced run/mode buttons driving a stepped 8-bit LED pattern FSM
module led_pattern_controller #(
    parameter int TICK_DIV  = 100000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_mode,
    input  logic [1:0] speed,
    output logic [7:0] led,
    output logic [1:0] state,
    output logic [1:0] mode
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
    localparam logic [31:0] TD      = 32'(TICK_DIV);
    localparam logic [31:0] DB_LAST = 32'(DB_CYCLES - 1);
    logic [1:0]  w_btn;
    logic [1:0]  r_s1, r_s2, r_db, r_db_q;
    logic [31:0] r_dbc [2];
    logic [1:0]  w_press;
    logic [31:0] w_shift, w_period;
    state_t      r_state, w_state_nx;
    logic [1:0]  r_mode, w_mode_nx;
    logic [7:0]  r_led, w_led_nx, w_seed, w_stepped;
    logic        r_dir, w_dir_nx, w_dir_stepped;
    logic [31:0] r_cnt, w_cnt_nx;
    logic        w_step;
    assign w_btn     = {btn_mode, btn_run};
    assign w_press   = r_db & ~r_db_q;
    assign w_shift   = TD >> speed;
    assign w_period  = (w_shift == 32'd0) ? 32'd1 : w_shift;
    assign w_mode_nx = r_mode + {1'b0, w_press[1]};
    assign w_seed    = (w_mode_nx == 2'd1) ? 8'h80 : 8'h01;
    assign w_step    = (r_state == RUN) && (r_cnt == w_period - 32'd1);
    assign led       = r_led;
    assign state     = r_state;
    assign mode      = r_mode;
    // synchronize each button, accept a new level only after DB_CYCLES disagreeing samples in a row
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_db   <= '0;
            r_db_q <= '0;
            for (int i = 0; i < 2; i++) r_dbc[i] <= '0;
        end else begin
            r_s1   <= w_btn;
            r_s2   <= r_s1;
            r_db_q <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_db[i]) r_dbc[i] <= '0;
                else if (r_dbc[i] >= DB_LAST) begin
                    r_db[i]  <= r_s2[i];
                    r_dbc[i] <= '0;
                end else r_dbc[i] <= r_dbc[i] + 32'd1;
            end
        end
    end
    // one-step advance of the pattern in the current mode (dir 1 = moving right)
    always_comb begin
        w_dir_stepped = r_dir;
        w_stepped     = 8'h00;
        if (r_mode != 2'd3 && r_led == 8'h00) begin
            w_stepped     = (r_mode == 2'd1) ? 8'h80 : 8'h01;
            w_dir_stepped = 1'b0;
        end else if (r_mode == 2'd0) w_stepped = {r_led[6:0], r_led[7]};
        else if (r_mode == 2'd1) w_stepped = {r_led[0], r_led[7:1]};
        else if (r_mode == 2'd2) begin
            w_stepped     = r_dir ? {1'b0, r_led[7:1]} : {r_led[6:0], 1'b0};
            w_dir_stepped = r_dir ? (w_stepped != 8'h01) : (w_stepped == 8'h80);
        end else w_stepped = (r_led == 8'hFF) ? 8'h00 : {r_led[6:0], 1'b1};
    end
    // next state, step counter and LED; seed loads from run/mode presses override a step
    always_comb begin
        w_state_nx = r_state;
        w_led_nx   = r_led;
        w_dir_nx   = r_dir;
        w_cnt_nx   = r_cnt;
        if (w_press[0]) w_state_nx = (r_state == RUN) ? PAUSE : RUN;
        if (r_state == RUN) w_cnt_nx = (r_cnt >= w_period - 32'd1) ? 32'd0 : r_cnt + 32'd1;
        else if (r_state == PAUSE && r_cnt >= w_period) w_cnt_nx = 32'd0;
        if (w_step) begin
            w_led_nx = w_stepped;
            w_dir_nx = w_dir_stepped;
        end
        if (r_state == IDLE) begin
            w_cnt_nx = 32'd0;
            w_dir_nx = 1'b0;
            w_led_nx = w_press[0] ? w_seed : 8'h00;
        end else if (w_press[1]) begin
            w_led_nx = w_seed;
            w_dir_nx = 1'b0;
            w_cnt_nx = 32'd0;
        end
    end
    // state, mode and pattern registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mode  <= 2'd0;
            r_led   <= 8'h00;
            r_dir   <= 1'b0;
            r_cnt   <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_mode  <= w_mode_nx;
            r_led   <= w_led_nx;
            r_dir   <= w_dir_nx;
            r_cnt   <= w_cnt_nx;
        end
    end
endmodule

// File: tb/tb_led_pattern_controller.sv
// tb_led_pattern_controller: directed checks of debounce, FSM, pattern modes, speed change and reset
module tb_led_pattern_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_mode = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [7:0] led;
    logic [1:0] state;
    logic [1:0] mode;
    int n_checks = 0;
    int n_fail = 0;

    led_pattern_controller #(.TICK_DIV(8), .DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn_run(btn_run), .btn_mode(btn_mode),
        .speed(speed), .led(led), .state(state), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (state === s) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_mode(input logic [1:0] m, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (mode === m) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", state); end
        n_checks++; if (mode !== 2'b00) begin n_fail++; $display("FAIL reset_mode: got %b want 00", mode); end
        n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %b want 00000000", led); end
        rst = 1'b0;
        tick(5);
        n_checks++; if (state !== 2'b00 || led !== 8'h00) begin n_fail++; $display("FAIL idle_hold: got state %b led %b want 00 00000000", state, led); end
    endtask

    task automatic test_run;
        int cyc;
        btn_run = 1'b1;
        wait_state(2'b01, cyc);
        n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL run_latency: got %0d cycles want 7", cyc); end
        n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL run_seed: got %b want 00000001", led); end
        tick(3);
        btn_run = 1'b0;
        tick(4);
        n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL run_before_step: got %b want 00000001", led); end
        tick(1);
        n_checks++; if (led !== 8'h02) begin n_fail++; $display("FAIL run_first_step: got %b want 00000010", led); end
        tick(56);
        n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL run_full_rotation: got %b want 00000001", led); end
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL run_state_kept: got %b want 01", state); end
    endtask

    task automatic test_debounce;
        int changes;
        logic [1:0] prev;
        btn_run = 1'b1;
        tick(3);
        btn_run = 1'b0;
        tick(15);
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL glitch_ignored: got %b want 01", state); end
        changes = 0;
        prev = state;
        btn_run = 1'b1;
        for (int i = 0; i < 110; i++) begin
            tick(1);
            if (state !== prev) changes++;
            prev = state;
        end
        btn_run = 1'b0;
        tick(10);
        n_checks++; if (changes !== 1) begin n_fail++; $display("FAIL held_one_transition: got %0d want 1", changes); end
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL held_paused: got %b want 10", state); end
    endtask

    task automatic test_pingpong;
        int cyc;
        btn_run = 1'b1;
        wait_state(2'b01, cyc);
        btn_run = 1'b0;
        n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL resume_from_pause: got state %b want 01", state); end
        tick(10);
        btn_mode = 1'b1;
        wait_mode(2'd1, cyc);
        n_checks++; if (led !== 8'h80) begin n_fail++; $display("FAIL mode1_seed: got %b want 10000000 (mode %b)", led, mode); end
        n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL mode_keeps_state: got %b want 01", state); end
        btn_mode = 1'b0;
        tick(12);
        btn_mode = 1'b1;
        wait_mode(2'd2, cyc);
        n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL mode2_seed: got %b want 00000001 (mode %b)", led, mode); end
        tick(3);
        btn_mode = 1'b0;
        tick(53);
        n_checks++; if (led !== 8'h80) begin n_fail++; $display("FAIL pingpong_top: got %b want 10000000", led); end
        tick(7);
        n_checks++; if (led !== 8'h80) begin n_fail++; $display("FAIL pingpong_hold_top: got %b want 10000000", led); end
        tick(1);
        n_checks++; if (led !== 8'h40) begin n_fail++; $display("FAIL pingpong_reverse: got %b want 01000000", led); end
    endtask

    task automatic test_fill;
        int cyc;
        btn_mode = 1'b1;
        wait_mode(2'd3, cyc);
        n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL fill_seed: got %b want 00000001 (mode %b)", led, mode); end
        tick(3);
        btn_mode = 1'b0;
        tick(53);
        n_checks++; if (led !== 8'hFF) begin n_fail++; $display("FAIL fill_full: got %b want 11111111", led); end
        tick(8);
        n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL fill_empty: got %b want 00000000", led); end
        tick(8);
        n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL fill_restart: got %b want 00000001", led); end
    endtask

    task automatic test_pause_speed;
        int cyc;
        btn_mode = 1'b1;
        wait_mode(2'd0, cyc);
        n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL mode_wrap_seed: got %b want 00000001 (mode %b)", led, mode); end
        btn_mode = 1'b0;
        btn_run = 1'b1;
        wait_state(2'b10, cyc);
        btn_run = 1'b0;
        n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL pause_latency: got %0d cycles want 7", cyc); end
        tick(20);
        n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL pause_frozen: got %b want 00000001", led); end
        n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL pause_state: got %b want 10", state); end
        speed = 2'd2;
        tick(3);
        btn_run = 1'b1;
        wait_state(2'b01, cyc);
        btn_run = 1'b0;
        n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL resume_led: got %b want 00000001", led); end
        tick(1);
        n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL resume_no_early_step: got %b want 00000001", led); end
        tick(1);
        n_checks++; if (led !== 8'h02) begin n_fail++; $display("FAIL fast_first_step: got %b want 00000010", led); end
        tick(2);
        n_checks++; if (led !== 8'h04) begin n_fail++; $display("FAIL fast_second_step: got %b want 00000100", led); end
        speed = 2'd0;
    endtask

    task automatic test_simultaneous_and_reset;
        int cyc;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        btn_run = 1'b1;
        btn_mode = 1'b1;
        wait_state(2'b01, cyc);
        n_checks++; if (cyc !== 7) begin n_fail++; $display("FAIL both_latency: got %0d cycles want 7", cyc); end
        n_checks++; if (mode !== 2'b01) begin n_fail++; $display("FAIL both_mode: got %b want 01", mode); end
        n_checks++; if (led !== 8'h80) begin n_fail++; $display("FAIL both_seed: got %b want 10000000", led); end
        btn_run = 1'b0;
        btn_mode = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(1);
        n_checks++; if (state !== 2'b00 || mode !== 2'b00 || led !== 8'h00) begin n_fail++; $display("FAIL midrun_reset: got state %b mode %b led %b want 00 00 00000000", state, mode, led); end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_idle_mode;
        int cyc;
        btn_mode = 1'b1;
        wait_mode(2'd1, cyc);
        btn_mode = 1'b0;
        n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL idle_mode_advance: got %b want 01", mode); end
        n_checks++; if (state !== 2'b00 || led !== 8'h00) begin n_fail++; $display("FAIL idle_mode_quiet: got state %b led %b want 00 00000000", state, led); end
        tick(10);
    endtask

    initial begin
        test_reset();
        test_run();
        test_debounce();
        test_pingpong();
        test_fill();
        test_pause_speed();
        test_simultaneous_and_reset();
        test_idle_mode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
